tcn_dilated_actbuffer: RTL and testbench
========================================

Name: tcn_dilated_actbuffer

Overview:
Circular time-step buffer for TCN layers. It stores the last DEPTH time steps of encoded activations, each time step being NUMWORDS words of WORDWIDTH bits. On each read it returns K dilated taps (t, t-D, ..., t-(K-1)D) of one word index in a single access. It sits between the output writeback stream and the activation decoders. It generalises the fixed-shift activation memory with a runtime dilation, a runtime window depth, partial-fill tracking, handshaked streaming writes and flush.

Parameters:
WORDWIDTH, 80, bits per encoded activation word (trit-encoded, multiple of 8)
NUMWORDS, 8, words per time step (one per weight-stagger slice)
DEPTH, 24, maximum stored time steps
K, 3, taps returned per read
CW, $clog2(DEPTH+1), width of the depth, dilation and fill fields

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset; synchronous and active-high
flush_i  in  1  discard all stored time steps and any partial write
cfg_valid_i  in  1  configuration request
cfg_ready_o  out  1  configuration can be accepted this cycle
cfg_depth_i  in  CW  active window length, 1..DEPTH
cfg_dilation_i  in  CW  tap spacing, >=1
cfg_error_o  out  1  one-cycle pulse when a config is rejected
wr_valid_i  in  1  write word valid
wr_ready_o  out  1  write word accepted
wr_data_i  in  WORDWIDTH  encoded word; the word index is implicit
rd_req_i  in  1  read request
rd_word_i  in  $clog2(NUMWORDS)  word index to read
rd_valid_o  out  1  read data valid
rd_data_o  out  K x WORDWIDTH  taps; index 0 is oldest, K-1 is newest
rd_tap_valid_o  out  K  per-tap: the referenced time step exists
fill_o  out  CW  number of valid time steps, 0..depth

Behaviour:
- State: mem[DEPTH][NUMWORDS] in flip-flops, not reset. Registers: hp (next slot to write), wc (word counter), fill, depth_q, dil_q.
- Reset: hp=0, wc=0, fill=0, depth_q=DEPTH, dil_q=1. All outputs are 0, except cfg_ready_o=1 and wr_ready_o=1 from the first cycle after reset.
- Write FSM has two states:
  - IDLE: wc==0.
  - PARTIAL: 0<wc<NUMWORDS.
  - A write handshake (wr_valid_i & wr_ready_o) stores mem[hp][wc]=wr_data_i and increments wc.
  - On the handshake with wc==NUMWORDS-1 (commit): wc=0; hp=(hp+1==depth_q)?0:hp+1; fill=min(fill+1, depth_q); return to IDLE.
  - wr_ready_o=~flush_i. No backpressure otherwise, because storage is flops.
- Config:
  - cfg_ready_o=(state==IDLE) & ~wr_valid_i & ~flush_i.
  - On accept: legal iff 1<=cfg_depth_i<=DEPTH, cfg_dilation_i>=1 and (K-1)*cfg_dilation_i < cfg_depth_i. Compute with CW+$clog2(K) bits so the product never overflows.
  - Legal config: latch depth and dilation; hp=0; fill=0.
  - Illegal config: keep the old config, pulse cfg_error_o for 1 cycle, leave state unchanged.
- Flush: hp=0, wc=0, fill=0 and any partial time step is discarded; config is retained. Flush wins over a write or config in the same cycle.
- Read:
  - rd_req_i is always accepted.
  - rd_valid_o rises the cycle after the request and lasts one cycle per request, so back-to-back requests give back-to-back valids.
  - Data and tap-valids come from the state sampled in the request cycle, i.e. before any commit, flush or config in that cycle.
  - newest slot n=(hp-1) mod depth_q. Tap j has age a=(K-1-j)*dil_q, slot (n-a) mod depth_q, wrapping within depth_q and not DEPTH.
  - rd_tap_valid_o[j]=(a<fill) & (rd_word_i<NUMWORDS). An invalid tap drives all-zero data.
  - A partial (uncommitted) time step is never visible to reads.
- Wrap-around: once fill==depth_q, each commit overwrites the oldest slot; fill saturates.
- Reset mid-write: the partial word count is lost and no time step is committed.
- When rd_valid_o is 0, rd_data_o and rd_tap_valid_o are 0.

Test Plan:
- Reset, then read word 0 -> rd_valid_o=1 one cycle later; rd_tap_valid_o=000; data 0; fill_o=0.
- Default cfg, dil=1: commit time steps T0..T2 (word w=16*t+w), read word 3 -> taps {T0w3, T1w3, T2w3}=0x03, 0x13, 0x23; tap_valid=111.
- cfg depth=5, dil=2: commit 7 steps (fill saturates at 5, wrap), read word 1 -> taps T2, T4, T6 word 1; fill_o=5.
- cfg depth=4, dil=2 with K=3 -> (K-1)*2=4 is not <4, so cfg_error_o pulses; config unchanged; a later legal cfg clears fill to 0.
- Write 5 of 8 words, then assert flush_i together with wr_valid_i -> wc=0, fill=0, the word is dropped; cfg_ready_o returns next cycle.
- Read request in the same cycle as a commit -> returned taps exclude the new step; a read one cycle later includes it as tap K-1.

Source files
------------

// File: rtl/tcn_dilated_actbuffer.sv
// -----------------------------------------------------------------------------
// tcn_dilated_actbuffer
//
// Circular time-step buffer for TCN layers. It holds the most recent depth_q
// time steps of encoded activations, NUMWORDS words of WORDWIDTH bits each.
// A read returns K dilated taps (t-(K-1)D .. t) of one word index in a single
// access, one cycle after the request.
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   flush_i         drop every stored time step and any partial write
//   cfg_valid_i     configuration request
//   cfg_ready_o     configuration can be accepted this cycle
//   cfg_depth_i     active window length, 1..DEPTH
//   cfg_dilation_i  tap spacing, >= 1
//   cfg_error_o     one-cycle pulse after a rejected configuration
//   wr_valid_i      write word valid
//   wr_ready_o      write word accepted
//   wr_data_i       encoded word; word index is implicit (sequential)
//   rd_req_i        read request, always accepted
//   rd_word_i       word index to read
//   rd_valid_o      read data valid, one cycle after the request
//   rd_data_o       K taps packed; tap 0 (oldest) in the low bits
//   rd_tap_valid_o  per-tap flag: the referenced time step exists
//   fill_o          number of valid time steps, 0..depth
// -----------------------------------------------------------------------------
module tcn_dilated_actbuffer #(
    parameter int WORDWIDTH = 80,
    parameter int NUMWORDS  = 8,
    parameter int DEPTH     = 24,
    parameter int K         = 3,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [CW-1:0]                 cfg_depth_i,
    input  logic [CW-1:0]                 cfg_dilation_i,
    output logic                          cfg_error_o,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [WORDWIDTH-1:0]          wr_data_i,
    input  logic                          rd_req_i,
    input  logic [$clog2(NUMWORDS)-1:0]   rd_word_i,
    output logic                          rd_valid_o,
    output logic [K*WORDWIDTH-1:0]        rd_data_o,
    output logic [K-1:0]                  rd_tap_valid_o,
    output logic [CW-1:0]                 fill_o
);

    localparam int WIW = $clog2(NUMWORDS);
    // Wide enough for (K-1)*dilation without overflow.
    localparam int AW  = CW + $clog2(K);

    typedef enum logic {
        ST_IDLE,
        ST_PARTIAL
    } wr_state_e;

    // Storage
    // NOTE: the activation array is deliberately left out of reset; fill_q
    // guards every read, so stale contents are never observable.
    logic [WORDWIDTH-1:0] mem [DEPTH][NUMWORDS];

    // Control state
    wr_state_e      state_q, state_d;
    logic [WIW-1:0] wc_q, wc_d;
    logic [CW-1:0]  hp_q, hp_d;
    logic [CW-1:0]  fill_q, fill_d;
    logic [CW-1:0]  depth_q, depth_d;
    logic [CW-1:0]  dil_q, dil_d;
    logic           cfg_err_q, cfg_err_d;

    // Read pipeline registers
    logic                   rd_valid_q;
    logic [K*WORDWIDTH-1:0] rd_data_q;
    logic [K-1:0]           rd_tap_valid_q;

    // Handshakes
    logic          wr_fire;
    logic          cfg_fire;
    logic          cfg_legal;
    logic [AW-1:0] cfg_span;
    logic [CW-1:0] hp_inc;

    assign wr_ready_o  = ~flush_i;
    assign cfg_ready_o = (state_q == ST_IDLE) & ~wr_valid_i & ~flush_i;
    assign wr_fire     = wr_valid_i & wr_ready_o;
    assign cfg_fire    = cfg_valid_i & cfg_ready_o;
    assign hp_inc      = hp_q + CW'(1);

    // The window must be long enough to hold the oldest tap.
    assign cfg_span  = AW'(K - 1) * AW'(cfg_dilation_i);
    assign cfg_legal = (cfg_depth_i != '0) &&
                       (cfg_depth_i <= CW'(DEPTH)) &&
                       (cfg_dilation_i != '0) &&
                       (cfg_span < AW'(cfg_depth_i));

    // Next-state logic: flush beats config beats write.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        wc_d      = wc_q;
        hp_d      = hp_q;
        fill_d    = fill_q;
        depth_d   = depth_q;
        dil_d     = dil_q;
        cfg_err_d = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
            wc_d    = '0;
            hp_d    = '0;
            fill_d  = '0;
        end else if (cfg_fire) begin
            if (cfg_legal) begin
                depth_d = cfg_depth_i;
                dil_d   = cfg_dilation_i;
                hp_d    = '0;
                fill_d  = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (wr_fire) begin
            if (wc_q == WIW'(NUMWORDS - 1)) begin
                // Commit: the time step becomes visible to reads.
                state_d = ST_IDLE;
                wc_d    = '0;
                hp_d    = (hp_inc == depth_q) ? '0 : hp_inc;
                fill_d  = (fill_q < depth_q) ? fill_q + CW'(1) : depth_q;
            end else begin
                state_d = ST_PARTIAL;
                wc_d    = wc_q + WIW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values sampled at the edge.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wc_q      <= '0;
            hp_q      <= '0;
            fill_q    <= '0;
            depth_q   <= CW'(DEPTH);
            dil_q     <= CW'(1);
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            hp_q      <= hp_d;
            fill_q    <= fill_d;
            depth_q   <= depth_d;
            dil_q     <= dil_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[hp_q][wc_q] <= wr_data_i;
        end
    end

    // Tap address generation from the pre-update state of this cycle.
    logic [CW-1:0]          newest;
    logic [AW-1:0]          tap_age  [K];
    logic [AW-1:0]          tap_pos  [K];
    logic [K-1:0]           tap_ok;
    logic [K*WORDWIDTH-1:0] tap_data;
    logic                   word_ok;

    assign newest  = (hp_q == '0) ? depth_q - CW'(1) : hp_q - CW'(1);
    assign word_ok = (32'(rd_word_i) < NUMWORDS);

    always_comb begin
        tap_ok   = '0;
        tap_data = '0;
        for (int j = 0; j < K; j++) begin
            tap_age[j] = AW'(K - 1 - j) * AW'(dil_q);
            // Wrap within the active window, not the physical DEPTH.
            if (AW'(newest) >= tap_age[j]) begin
                tap_pos[j] = AW'(newest) - tap_age[j];
            end else begin
                tap_pos[j] = AW'(newest) + AW'(depth_q) - tap_age[j];
            end
            tap_ok[j] = (tap_age[j] < AW'(fill_q)) & word_ok;
            if (tap_ok[j]) begin
                tap_data[j*WORDWIDTH +: WORDWIDTH] = mem[CW'(tap_pos[j])][rd_word_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_tap_valid_q <= '0;
        end else begin
            rd_valid_q     <= rd_req_i;
            rd_data_q      <= rd_req_i ? tap_data : '0;
            rd_tap_valid_q <= rd_req_i ? tap_ok : '0;
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign rd_tap_valid_o = rd_tap_valid_q;
    assign cfg_error_o    = cfg_err_q;
    assign fill_o         = fill_q;

endmodule

// File: tb/tb_tcn_dilated_actbuffer.sv
// -----------------------------------------------------------------------------
// tb_tcn_dilated_actbuffer
//
// Directed bench for tcn_dilated_actbuffer with default parameters. Inputs are
// driven on the falling edge, registered outputs sampled on the next falling
// edge. Expected values are hand-computed; word w of time step t is 16*t+w.
// -----------------------------------------------------------------------------
module tb_tcn_dilated_actbuffer;

    localparam int WORDWIDTH = 80;
    localparam int NUMWORDS  = 8;
    localparam int DEPTH     = 24;
    localparam int K         = 3;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int WIW       = $clog2(NUMWORDS);

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic [CW-1:0]          cfg_depth_i;
    logic [CW-1:0]          cfg_dilation_i;
    logic                   cfg_error_o;
    logic                   wr_valid_i;
    logic                   wr_ready_o;
    logic [WORDWIDTH-1:0]   wr_data_i;
    logic                   rd_req_i;
    logic [WIW-1:0]         rd_word_i;
    logic                   rd_valid_o;
    logic [K*WORDWIDTH-1:0] rd_data_o;
    logic [K-1:0]           rd_tap_valid_o;
    logic [CW-1:0]          fill_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    tcn_dilated_actbuffer #(
        .WORDWIDTH (WORDWIDTH),
        .NUMWORDS  (NUMWORDS),
        .DEPTH     (DEPTH),
        .K         (K)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_depth_i    (cfg_depth_i),
        .cfg_dilation_i (cfg_dilation_i),
        .cfg_error_o    (cfg_error_o),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_data_i      (wr_data_i),
        .rd_req_i       (rd_req_i),
        .rd_word_i      (rd_word_i),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .rd_tap_valid_o (rd_tap_valid_o),
        .fill_o         (fill_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: rising edge, then back to the falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic write_word(input logic [WORDWIDTH-1:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic commit_step(input int t);
        for (int w = 0; w < NUMWORDS; w++) write_word(WORDWIDTH'(16 * t + w));
    endtask

    task automatic do_read(input int w);
        rd_req_i  = 1'b1;
        rd_word_i = WIW'(w);
        tick();
        rd_req_i  = 1'b0;
    endtask

    task automatic do_cfg(input int d, input int dil);
        cfg_valid_i    = 1'b1;
        cfg_depth_i    = CW'(d);
        cfg_dilation_i = CW'(dil);
        tick();
        cfg_valid_i    = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        cfg_valid_i    = 1'b0;
        cfg_depth_i    = '0;
        cfg_dilation_i = '0;
        wr_valid_i     = 1'b0;
        wr_data_i      = '0;
        rd_req_i       = 1'b0;
        rd_word_i      = '0;

        // Reset
        @(negedge clk_i);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("rst_cfg_ready", 256'(cfg_ready_o), 256'(1'b1));
        check("rst_wr_ready", 256'(wr_ready_o), 256'(1'b1));
        check("rst_fill", 256'(fill_o), 256'(0));
        check("rst_rd_valid", 256'(rd_valid_o), 256'(1'b0));
        check("rst_cfg_error", 256'(cfg_error_o), 256'(1'b0));

        // Read of an empty buffer
        do_read(0);
        check("empty_rd_valid", 256'(rd_valid_o), 256'(1'b1));
        check("empty_tap_valid", 256'(rd_tap_valid_o), 256'(3'b000));
        check("empty_data", 256'(rd_data_o), 256'(0));
        tick();
        check("idle_rd_valid", 256'(rd_valid_o), 256'(1'b0));

        // Default config (depth 24, dil 1): partially filled window
        commit_step(0);
        check("t0_fill", 256'(fill_o), 256'(1));
        do_read(3);
        check("t0_tap_valid", 256'(rd_tap_valid_o), 256'(3'b100));
        check("t0_data", 256'(rd_data_o), 256'({80'h03, 80'h0, 80'h0}));
        commit_step(1);
        commit_step(2);
        check("t2_fill", 256'(fill_o), 256'(3));
        do_read(3);
        check("t2_tap_valid", 256'(rd_tap_valid_o), 256'(3'b111));
        check("t2_data", 256'(rd_data_o), 256'({80'h23, 80'h13, 80'h03}));

        // depth 5, dil 2: wrap with saturated fill
        do_cfg(5, 2);
        check("cfg52_error", 256'(cfg_error_o), 256'(1'b0));
        check("cfg52_fill", 256'(fill_o), 256'(0));
        for (int t = 0; t < 7; t++) commit_step(t);
        check("wrap_fill", 256'(fill_o), 256'(5));
        do_read(1);
        check("wrap_tap_valid", 256'(rd_tap_valid_o), 256'(3'b111));
        check("wrap_data", 256'(rd_data_o), 256'({80'h61, 80'h41, 80'h21}));

        // depth 4, dil 2: (K-1)*2 == 4 is rejected, config and state unchanged
        do_cfg(4, 2);
        check("bad_cfg_error", 256'(cfg_error_o), 256'(1'b1));
        tick();
        check("bad_cfg_pulse_end", 256'(cfg_error_o), 256'(1'b0));
        check("bad_cfg_fill", 256'(fill_o), 256'(5));
        do_read(1);
        check("bad_cfg_data", 256'(rd_data_o), 256'({80'h61, 80'h41, 80'h21}));

        // Legal config clears the fill
        do_cfg(4, 1);
        check("cfg41_error", 256'(cfg_error_o), 256'(1'b0));
        check("cfg41_fill", 256'(fill_o), 256'(0));

        // Flush during a partial write
        commit_step(0);
        check("pre_flush_fill", 256'(fill_o), 256'(1));
        for (int w = 0; w < 5; w++) write_word(WORDWIDTH'(16 + w));
        #1;
        check("partial_cfg_ready", 256'(cfg_ready_o), 256'(1'b0));
        flush_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = WORDWIDTH'(8'h15);
        #1;
        check("flush_wr_ready", 256'(wr_ready_o), 256'(1'b0));
        tick();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        #1;
        check("flush_fill", 256'(fill_o), 256'(0));
        check("flush_cfg_ready", 256'(cfg_ready_o), 256'(1'b1));
        commit_step(2);
        check("post_flush_fill", 256'(fill_o), 256'(1));
        do_read(0);
        check("post_flush_tv", 256'(rd_tap_valid_o), 256'(3'b100));
        check("post_flush_w0", 256'(rd_data_o), 256'({80'h20, 80'h0, 80'h0}));
        do_read(5);
        check("post_flush_w5", 256'(rd_data_o), 256'({80'h25, 80'h0, 80'h0}));

        // Read in the commit cycle sees the old state; the next read sees the new step
        for (int w = 0; w < 7; w++) write_word(WORDWIDTH'(8'h30 + w));
        wr_valid_i = 1'b1;
        wr_data_i  = WORDWIDTH'(8'h37);
        rd_req_i   = 1'b1;
        rd_word_i  = WIW'(2);
        tick();
        wr_valid_i = 1'b0;
        check("same_cyc_valid", 256'(rd_valid_o), 256'(1'b1));
        check("same_cyc_tv", 256'(rd_tap_valid_o), 256'(3'b100));
        check("same_cyc_data", 256'(rd_data_o), 256'({80'h22, 80'h0, 80'h0}));
        tick();
        check("b2b_valid", 256'(rd_valid_o), 256'(1'b1));
        check("b2b_tv", 256'(rd_tap_valid_o), 256'(3'b110));
        check("b2b_data", 256'(rd_data_o), 256'({80'h32, 80'h22, 80'h0}));
        check("b2b_fill", 256'(fill_o), 256'(2));
        rd_req_i = 1'b0;
        tick();
        check("end_rd_valid", 256'(rd_valid_o), 256'(1'b0));
        check("end_tv", 256'(rd_tap_valid_o), 256'(3'b000));
        check("end_data", 256'(rd_data_o), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
